// File: rtl/sbi_ram_ctrl.sv
// Burst front-end for a single-port RAM: walks write beats straight into the RAM and
// turns the RAM's one-cycle registered read into a backpressured valid/ready stream.
module sbi_ram_ctrl #(
    parameter int Width = 32,
    parameter int Depth = 256,
    parameter int LenW  = 8,
    localparam int Aw   = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_write_i,
    input  logic [Aw-1:0]    req_addr_i,
    input  logic [LenW-1:0]  req_len_i,

    input  logic             wvalid_i,
    output logic             wready_o,
    input  logic [Width-1:0] wdata_i,

    output logic             rvalid_o,
    input  logic             rready_i,
    output logic [Width-1:0] rdata_o,
    output logic             rlast_o,

    output logic             done_o,

    output logic             ram_we_o,
    output logic             ram_re_o,
    output logic [Aw-1:0]    ram_addr_o,
    output logic [Width-1:0] ram_wdata_o,
    input  logic [Width-1:0] ram_rdata_i
);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    localparam logic [Aw-1:0] AddrMax = Aw'(Depth - 1);

    state_t          state_q, state_d;
    logic [Aw-1:0]   addr_q, addr_d;
    logic [LenW-1:0] cnt_q, cnt_d;
    logic            issue_left_q, issue_left_d;
    logic            pend_q, pend_d;
    logic            last_q, last_d;
    logic            done_q, done_d;
    logic            issue;
    logic [Aw-1:0]   addr_inc;

    // Wraps correctly even when Depth is not a power of two.
    assign addr_inc = (addr_q == AddrMax) ? '0 : addr_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            issue_left_q <= 1'b0;
            pend_q       <= 1'b0;
            last_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            issue_left_q <= issue_left_d;
            pend_q       <= pend_d;
            last_q       <= last_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        issue_left_d = issue_left_q;
        pend_d       = pend_q;
        last_d       = last_q;
        done_d       = 1'b0;
        req_ready_o  = 1'b0;
        wready_o     = 1'b0;
        ram_we_o     = 1'b0;
        ram_re_o     = 1'b0;
        issue        = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    addr_d       = req_addr_i;
                    cnt_d        = req_len_i;
                    pend_d       = 1'b0;
                    last_d       = 1'b0;
                    issue_left_d = !req_write_i;
                    state_d      = req_write_i ? WRITE : READ;
                end
            end

            WRITE: begin
                wready_o = 1'b1;
                ram_we_o = wvalid_i;
                if (wvalid_i) begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d  = cnt_q - 1'b1;
                        addr_d = addr_inc;
                    end
                end
            end

            READ: begin
                // A new read may only overwrite the RAM output once the held beat leaves.
                issue    = issue_left_q && (!pend_q || rready_i);
                ram_re_o = issue;
                if (issue) begin
                    pend_d = 1'b1;
                    last_d = (cnt_q == '0);
                    if (cnt_q == '0) begin
                        issue_left_d = 1'b0;
                    end else begin
                        cnt_d  = cnt_q - 1'b1;
                        addr_d = addr_inc;
                    end
                end else if (pend_q && rready_i) begin
                    pend_d = 1'b0;
                end
                if (pend_q && last_q && rready_i) begin
                    state_d = IDLE;
                    pend_d  = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign rvalid_o    = pend_q;
    assign rlast_o     = pend_q && last_q;
    assign rdata_o     = ram_rdata_i;
    assign done_o      = done_q;
    assign ram_addr_o  = addr_q;
    assign ram_wdata_o = wdata_i;

endmodule

// File: tb/tb_sbi_ram_ctrl.sv
// Randomized bench for sbi_ram_ctrl: a behavioural RAM, a reference memory image
// and per-beat expectations derived from burst start address and length.
module tb_sbi_ram_ctrl;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_write;
    logic [7:0]  req_addr, req_len;
    logic        wvalid;
    logic [31:0] wdata;
    logic        rready;
    logic        req_ready_o, wready_o, rvalid_o, rlast_o, done_o;
    logic        ram_we_o, ram_re_o;
    logic [7:0]  ram_addr_o;
    logic [31:0] ram_wdata_o, rdata_o;
    logic [31:0] ram_rdata;

    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] wq[$];

    int checks_cnt   = 0;
    int failures_cnt = 0;
    int done_seen    = 0;
    int bursts_done  = 0;

    always #5 clk = ~clk;

    sbi_ram_ctrl dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready_o),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_len_i   (req_len),
        .wvalid_i    (wvalid),
        .wready_o    (wready_o),
        .wdata_i     (wdata),
        .rvalid_o    (rvalid_o),
        .rready_i    (rready),
        .rdata_o     (rdata_o),
        .rlast_o     (rlast_o),
        .done_o      (done_o),
        .ram_we_o    (ram_we_o),
        .ram_re_o    (ram_re_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata)
    );

    // RAM with one-cycle registered read; output holds while not reading.
    always @(posedge clk) begin
        if (ram_we_o) mem[ram_addr_o] <= ram_wdata_o;
        if (ram_re_o) ram_rdata <= mem[ram_addr_o];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            failures_cnt++;
            $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("excl_we_re", 32'(ram_we_o & ram_re_o), 32'd0);
            check("no_reissue_stall", 32'(rvalid_o & ~rready & ram_re_o), 32'd0);
            if (done_o) done_seen++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int a, input int len, input int gap_pct, input int lead_gap);
        int beat = 0;
        int cyc  = 0;
        step();
        req_valid = 1; req_write = 1; req_addr = 8'(a); req_len = 8'(len);
        #1;
        check("wr_req_ready", 32'(req_ready_o), 32'd1);
        step();
        req_valid = 0;
        while (beat <= len && cyc < 3000) begin
            wvalid = (cyc >= lead_gap) && ($urandom_range(99) >= gap_pct);
            wdata  = $urandom;
            if (wvalid && wq.size() > 0) wdata = wq.pop_front();
            #1;
            check("wr_wready", 32'(wready_o), 32'd1);
            check("wr_we", 32'(ram_we_o), 32'(wvalid));
            check("wr_done_idle", 32'(done_o), 32'd0);
            if (wvalid) begin
                check("wr_addr", 32'(ram_addr_o), 32'((a + beat) % DEPTH));
                check("wr_data", ram_wdata_o, wdata);
                ref_mem[(a + beat) % DEPTH] = wdata;
                beat++;
            end
            step();
            cyc++;
        end
        wvalid = 0;
        if (cyc >= 3000) check("wr_timeout", 32'd1, 32'd0);
        #1;
        check("wr_done", 32'(done_o), 32'd1);
        check("wr_ready_after", 32'(req_ready_o), 32'd1);
        step();
        #1;
        check("wr_done_once", 32'(done_o), 32'd0);
        bursts_done++;
        $display("write burst addr=%02h len=%0d beats=%0d cycles=%0d", a, len, beat, cyc);
    endtask

    // mode 0: rready always high, 1: random, 2: pattern 1,0,0,...
    task automatic do_read(input int a, input int len, input int mode);
        int idx = 0;
        int cyc = 1;
        logic [31:0] prev_d = '0;
        logic prev_l = 1'b0;
        logic prev_stall = 1'b0;
        step();
        req_valid = 1; req_write = 0; req_addr = 8'(a); req_len = 8'(len);
        #1;
        check("rd_req_ready", 32'(req_ready_o), 32'd1);
        step();
        req_valid = 0;
        while (idx <= len && cyc < 4000) begin
            rready = (mode == 0) ? 1'b1 :
                     (mode == 2) ? ((cyc - 1) % 3 == 0) : 1'($urandom_range(1));
            #1;
            if (prev_stall) begin
                check("rd_stall_valid", 32'(rvalid_o), 32'd1);
                check("rd_stall_data", rdata_o, prev_d);
                check("rd_stall_last", 32'(rlast_o), 32'(prev_l));
            end
            if (rvalid_o && rready) begin
                check("rd_data", rdata_o, ref_mem[(a + idx) % DEPTH]);
                check("rd_last", 32'(rlast_o), 32'(idx == len));
                if (mode == 0) check("rd_latency", 32'(cyc), 32'(2 + idx));
                idx++;
            end
            prev_stall = rvalid_o && !rready;
            prev_d     = rdata_o;
            prev_l     = rlast_o;
            step();
            cyc++;
        end
        rready = 0;
        if (cyc >= 4000) check("rd_timeout", 32'd1, 32'd0);
        #1;
        check("rd_done", 32'(done_o), 32'd1);
        check("rd_ready_after", 32'(req_ready_o), 32'd1);
        check("rd_valid_after", 32'(rvalid_o), 32'd0);
        step();
        #1;
        check("rd_done_once", 32'(done_o), 32'd0);
        bursts_done++;
        $display("read burst addr=%02h len=%0d mode=%0d beats=%0d cycles=%0d", a, len, mode, idx, cyc);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_req_ready"}, 32'(req_ready_o), 32'd1);
        check({pfx, "_wready"},    32'(wready_o),    32'd0);
        check({pfx, "_rvalid"},    32'(rvalid_o),    32'd0);
        check({pfx, "_rlast"},     32'(rlast_o),     32'd0);
        check({pfx, "_done"},      32'(done_o),      32'd0);
        check({pfx, "_we"},        32'(ram_we_o),    32'd0);
        check({pfx, "_re"},        32'(ram_re_o),    32'd0);
        check({pfx, "_addr"},      32'(ram_addr_o),  32'd0);
    endtask

    initial begin
        int a, l;
        rst_n = 0; req_valid = 0; req_write = 0; req_addr = 0; req_len = 0;
        wvalid = 0; wdata = 0; rready = 0;
        repeat (3) step();
        #1;
        check_reset_values("reset");
        rst_n = 1;
        step();

        wq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        do_write(8'h10, 3, 0, 0);
        do_read(8'h10, 3, 0);

        wq = '{32'd1, 32'd2, 32'd3, 32'd4};
        do_write(8'hFE, 3, 0, 0);
        check("wrap_mem_fe", mem[8'hFE], 32'd1);
        check("wrap_mem_ff", mem[8'hFF], 32'd2);
        check("wrap_mem_00", mem[8'h00], 32'd3);
        check("wrap_mem_01", mem[8'h01], 32'd4);
        do_read(8'hFE, 3, 0);

        do_write(8'h40, 7, 30, 0);
        do_read(8'h40, 7, 2);

        wq = '{32'h5A};
        do_write(8'h80, 0, 0, 3);
        do_read(8'h80, 0, 0);

        // Abandon a read after two of four beats.
        do_write(8'h20, 3, 0, 0);
        step();
        req_valid = 1; req_write = 0; req_addr = 8'h20; req_len = 8'd3; rready = 1;
        step();
        req_valid = 0;
        repeat (3) step();
        #1;
        check("abort_pre_rvalid", 32'(rvalid_o), 32'd1);
        rst_n = 0;
        #1;
        check_reset_values("abort");
        rready = 0;
        repeat (2) step();
        rst_n = 1;
        repeat (3) begin
            step();
            #1;
            check("abort_no_done", 32'(done_o), 32'd0);
            check("abort_idle", 32'(req_ready_o), 32'd1);
        end
        $display("reset mid-burst done");
        do_read(8'h20, 3, 1);

        for (int i = 0; i < 16; i++) begin
            a = $urandom_range(DEPTH - 1);
            l = (i == 0) ? 255 : $urandom_range(15);
            do_write(a, l, $urandom_range(40), 0);
            do_read(a, l, $urandom_range(1));
        end

        repeat (2) step();
        check("done_count", 32'(done_seen), 32'(bursts_done));
        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
